// File: rtl/rv32i_pkg.sv
// Shared rv32i pipeline types: instruction class carried alongside each stage.
package rv32i_pkg;

   typedef enum logic [2:0] {
      R_TYPE,
      I_TYPE_ALU,
      I_TYPE_LOAD,
      I_TYPE_JALR,
      S_TYPE,
      B_TYPE,
      U_TYPE,
      J_TYPE
   } instr_type_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-detection bundle: Decode sources, Execute/Memory destinations and the stall/flush controls.
interface hazard_unit_if
   import rv32i_pkg::*;
#(
   parameter int REG_WIDTH = 5
);

   instr_type_t          regwriteE;
   logic [REG_WIDTH-1:0] Rs1D;
   logic [REG_WIDTH-1:0] Rs2D;
   logic [REG_WIDTH-1:0] RdE;
   logic [REG_WIDTH-1:0] RdM;
   logic                 stallD;
   logic                 flushE;

   // Pipeline-control side drives the stage fields and consumes stall/flush.
   modport master (
      output regwriteE, Rs1D, Rs2D, RdE, RdM,
      input  stallD, flushE
   );

   modport slave (
      input  regwriteE, Rs1D, Rs2D, RdE, RdM,
      output stallD, flushE
   );

endinterface

// File: rtl/hazard_unit.sv
// Load-use hazard detection: stalls Decode and bubbles Execute while a load in
// Execute or Memory writes a register the Decode instruction reads.
module hazard_unit
   import rv32i_pkg::*;
#(
   parameter int REG_WIDTH = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   hazard_unit_if.slave hz
);

   localparam logic [REG_WIDTH-1:0] REG_X0 = '0;

   logic loadE;
   logic loadM_d;
   logic loadM_q;
   logic lwstallE;
   logic lwstallM;
   logic stall;

   // The load in Execute always advances into Memory; only the follower is bubbled,
   // so the Memory flag is deliberately not gated by the flush.
   always_comb begin
      loadE   = (hz.regwriteE == I_TYPE_LOAD);
      loadM_d = loadE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         loadM_q <= 1'b0;
      end else begin
         loadM_q <= loadM_d;
      end
   end

   // loadM_q is evaluated first so an unknown RdM cannot leak through when no load is in Memory.
   always_comb begin
      lwstallE = loadE && (hz.RdE != REG_X0) &&
                 ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
      lwstallM = loadM_q && (hz.RdM != REG_X0) &&
                 ((hz.RdM == hz.Rs1D) || (hz.RdM == hz.Rs2D));
      stall    = rst_n && (lwstallE || lwstallM);
   end

   assign hz.stallD = stall;
   assign hz.flushE = stall;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit: driver queues hand-computed stall/flush, monitor checks.
module tb_hazard_unit;
   import rv32i_pkg::*;

   localparam int RW = 5;

   typedef struct {
      string       name;
      logic        rst_n;
      instr_type_t typ;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rdE;
      logic [4:0]  rdM;
      logic        exp;
   } vec_t;

   typedef struct {
      string name;
      logic  exp;
   } sb_t;

   logic clk = 1'b0;
   logic rst_n;

   hazard_unit_if #(.REG_WIDTH(RW)) hz ();

   hazard_unit #(.REG_WIDTH(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz.slave)
   );

   always #5 clk = ~clk;

   vec_t vecs[$];
   sb_t  sbq[$];
   int   applied = 0;
   int   miscompares = 0;

   task automatic add(input string n, input logic r, input instr_type_t t,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] de, input logic [4:0] dm, input logic e);
      vec_t v;
      v.name = n; v.rst_n = r; v.typ = t; v.rs1 = s1; v.rs2 = s2;
      v.rdE = de; v.rdM = dm; v.exp = e;
      vecs.push_back(v);
   endtask

   // Monitor: outputs are combinational, so each queued vector is checked mid-cycle.
   initial begin
      sb_t s;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            s = sbq.pop_front();
            applied++;
            if (hz.stallD !== s.exp || hz.flushE !== s.exp) begin
               miscompares++;
               $display("FAIL %s: stallD=%b flushE=%b, required both %b",
                        s.name, hz.stallD, hz.flushE, s.exp);
            end
         end
      end
   end

   initial begin
      sb_t s;
      logic [4:0] xreg;
      xreg = 'x;

      // Reset with hazard inputs active, then the directed sequence; each line is one cycle.
      add("rst_hold0",   0, I_TYPE_LOAD, 2, 3, 2, 2, 0);
      add("rst_hold1",   0, I_TYPE_LOAD, 2, 3, 2, 2, 0);
      add("ex_store",    1, S_TYPE,      2, 3, 2, 0, 0);
      add("ex_load_rs1", 1, I_TYPE_LOAD, 2, 3, 2, 0, 1);
      add("mem_load",    1, S_TYPE,      5, 3, 2, 5, 1);
      add("mem_cleared", 1, S_TYPE,      5, 3, 2, 5, 0);
      add("ex_both_src", 1, I_TYPE_LOAD, 6, 6, 6, 6, 1);
      add("x0_no_stall", 1, I_TYPE_LOAD, 0, 0, 0, 0, 0);
      add("ex_and_mem",  1, I_TYPE_LOAD, 7, 7, 7, 7, 1);
      add("rtype_nomat", 1, R_TYPE,      9, 4, 4, 7, 0);
      add("alu_rs2",     1, I_TYPE_ALU,  9, 4, 4, 7, 0);
      add("ex_load_rs2", 1, I_TYPE_LOAD, 1, 8, 8, 0, 1);
      add("mem_rs1",     1, S_TYPE,      8, 2, 3, 8, 1);
      add("btype_mem0",  1, B_TYPE,      8, 2, 8, 8, 0);
      add("rdm_unknown", 1, U_TYPE,      3, 4, 5, xreg, 0);
      add("consec_0",    1, I_TYPE_LOAD, 10, 1, 10, 0, 1);
      add("consec_1",    1, I_TYPE_LOAD, 10, 1, 10, 10, 1);
      add("consec_mem",  1, J_TYPE,      10, 1, 2, 10, 1);
      add("pre_rst",     1, I_TYPE_LOAD, 11, 1, 11, 0, 1);
      add("rst_midstall",0, I_TYPE_LOAD, 11, 1, 11, 11, 0);
      add("post_rst",    1, S_TYPE,      11, 1, 2, 11, 0);

      rst_n = 1'b0;
      hz.regwriteE = S_TYPE;
      hz.Rs1D = '0; hz.Rs2D = '0; hz.RdE = '0; hz.RdM = '0;

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         rst_n        = vecs[i].rst_n;
         hz.regwriteE = vecs[i].typ;
         hz.Rs1D      = vecs[i].rs1;
         hz.Rs2D      = vecs[i].rs2;
         hz.RdE       = vecs[i].rdE;
         hz.RdM       = vecs[i].rdM;
         s.name = vecs[i].name;
         s.exp  = vecs[i].exp;
         sbq.push_back(s);
      end

      // Bounded drain of the scoreboard.
      for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
      @(posedge clk);
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left unchecked, required 0", sbq.size());
      end
      if (applied != vecs.size()) begin
         miscompares++;
         $display("FAIL count: %0d vectors checked, required %0d", applied, vecs.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
